// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 device over the open-drain clock/data
// lines: clock inhibit, request-to-send, 8 data bits LSB first, odd parity,
// stop bit, then checks the device acknowledge and waits for bus idle.
//
// Optional feature: define PS2_TX_CLK_FILTER_EN to pass the synchronized
// PS/2 clock through an 8-cycle stability filter before edge detection.
//
// Ports:
//   clk            system clock
//   reset_ni       asynchronous active-low reset (releases both lines at once)
//   data_i         command byte to send
//   valid_i        send request; accepted when valid_i && ready_o
//   ready_o        high only while idle
//   busy_o         high from acceptance until the done/err pulse ends
//   done_o         one-cycle pulse: frame sent and acknowledged
//   err_o          one-cycle pulse: frame failed
//   err_code_o     01 = timeout, 10 = no acknowledge; holds until next error
//   ps2_clk_i      raw PS/2 clock line (asynchronous)
//   ps2_data_i     raw PS/2 data line (asynchronous)
//   ps2_clk_oe_o   1 = pull the clock line low
//   ps2_data_oe_o  1 = pull the data line low
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int FREQ_HZ    = 25000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int INH_CYC = FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC  = FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int INH_W   = (INH_CYC > 1) ? $clog2(INH_CYC + 1) : 1;
  localparam int TO_W    = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    BITS      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        sh_reg, sh_next;
  logic [3:0]        n_reg, n_next;
  logic [INH_W-1:0]  inh_cnt_reg, inh_cnt_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              clk_oe_reg, clk_oe_next;
  logic              data_oe_reg, data_oe_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic [1:0]        code_now;

  // ---------------------------------------------------------------------
  // Input synchronizers; bit 0 = clock, bit 1 = data. Idle lines are high.
  // ---------------------------------------------------------------------
  logic [1:0] meta_reg, sync_reg;
  logic       clk_s, data_s, clk_f, clk_f_d_reg, fall, par, timeout;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      meta_reg <= 2'b11;
      sync_reg <= 2'b11;
    end else begin
      meta_reg <= {ps2_data_i, ps2_clk_i};
      sync_reg <= meta_reg;
    end
  end

  assign clk_s  = sync_reg[0];
  assign data_s = sync_reg[1];

`ifdef PS2_TX_CLK_FILTER_EN
  // The filtered clock follows the synchronized clock only after it has
  // disagreed for FILT consecutive samples, so short glitches never
  // reach the edge detector.
  localparam int FILT = 8;
  logic [2:0] filt_cnt_reg;
  logic       filt_clk_reg;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      filt_cnt_reg <= '0;
      filt_clk_reg <= 1'b1;
    end else if (clk_s == filt_clk_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg == 3'(FILT - 1)) begin
      filt_cnt_reg <= '0;
      filt_clk_reg <= clk_s;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 3'd1;
    end
  end

  assign clk_f = filt_clk_reg;
`else
  assign clk_f = clk_s;
`endif

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) clk_f_d_reg <= 1'b1;
    else           clk_f_d_reg <= clk_f;
  end

  assign fall = clk_f_d_reg & ~clk_f;
  assign par  = ~^sh_reg;

  // A fall in the same cycle as the last allowed count wins over timeout.
  assign timeout = (state_reg == BITS || state_reg == ACK || state_reg == WAIT_IDLE)
                   && (to_cnt_reg == TO_LAST) && !fall;

  // ---------------------------------------------------------------------
  // State register (with datapath registers)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg    <= IDLE;
      sh_reg       <= '0;
      n_reg        <= '0;
      inh_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      err_code_reg <= 2'b00;
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      n_reg        <= n_next;
      inh_cnt_reg  <= inh_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      err_code_reg <= err_code_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (valid_i) state_next = INHIBIT;
      INHIBIT:   if (inh_cnt_reg == INH_LAST) state_next = RTS;
      RTS:       state_next = BITS;
      BITS: begin
        if (fall) begin
          if (n_reg == 4'd9) state_next = ACK;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      ACK: begin
        if (fall)         state_next = data_s ? IDLE : WAIT_IDLE;
        else if (timeout) state_next = IDLE;
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) state_next = IDLE;
        else if (timeout)    state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    sh_next      = sh_reg;
    n_next       = n_reg;
    inh_cnt_next = inh_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    data_oe_next = data_oe_reg;
    done_o       = 1'b0;
    err_o        = 1'b0;
    code_now     = err_code_reg;

    case (state_reg)
      IDLE: begin
        inh_cnt_next = '0;
        if (valid_i) begin
          sh_next = data_i;
          n_next  = 4'd0;
        end
      end
      INHIBIT: inh_cnt_next = inh_cnt_reg + INH_W'(1);
      RTS:     to_cnt_next = '0;
      BITS: begin
        if (fall) begin
          n_next      = n_reg + 4'd1;
          to_cnt_next = '0;
          // Data bits n=1..8 carry sh[n-1]; OE is the inverse of the level.
          if (n_next <= 4'd8)      data_oe_next = ~sh_reg[n_reg[2:0]];
          else if (n_next == 4'd9) data_oe_next = ~par;
          else                     data_oe_next = 1'b0;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
          if (timeout) begin
            err_o    = 1'b1;
            code_now = 2'b01;
          end
        end
      end
      ACK: begin
        if (fall) begin
          to_cnt_next = '0;
          if (data_s) begin
            err_o    = 1'b1;
            code_now = 2'b10;
          end
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
          if (timeout) begin
            err_o    = 1'b1;
            code_now = 2'b01;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_o = 1'b1;
        end else if (fall) begin
          to_cnt_next = '0;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
          if (timeout) begin
            err_o    = 1'b1;
            code_now = 2'b01;
          end
        end
      end
      default: ;
    endcase

    // Start bit: data goes low together with the last inhibit cycle.
    if (state_next == INHIBIT && inh_cnt_next == INH_LAST) data_oe_next = 1'b1;
    if (state_next == IDLE) data_oe_next = 1'b0;

    clk_oe_next   = (state_next == INHIBIT);
    err_code_next = err_o ? code_now : err_code_reg;
  end

  assign ready_o       = (state_reg == IDLE);
  assign busy_o        = ~ready_o;
  assign err_code_o    = err_code_next;
  assign ps2_clk_oe_o  = clk_oe_reg;
  assign ps2_data_oe_o = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH_CYC = 2500;  // 25 MHz * 100 us
  localparam int TO_CYC  = 2500;  // 25 MHz * 100 us

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o, busy_o, done_o, err_o;
  logic [1:0] err_code_o;
  logic       ps2_clk_oe_o, ps2_data_oe_o;

  // Open-drain bus: low if either side pulls it low.
  logic bfm_clk = 1'b1, bfm_data_low = 1'b0, glitch = 1'b0;
  logic ps2_clk_line, ps2_data_line;
  assign ps2_clk_line  = ~ps2_clk_oe_o & bfm_clk & ~glitch;
  assign ps2_data_line = ~ps2_data_oe_o & ~bfm_data_low;

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  int done_cyc = 0, err_cyc = 0, acc_cyc = 0;
  logic [1:0] last_code = 2'b00;

  ps2_host_tx #(
    .FREQ_HZ   (25000000),
    .INHIBIT_US(100),
    .TIMEOUT_US(100)
  ) dut (
    .clk          (clk),
    .reset_ni     (reset_ni),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .ps2_clk_i    (ps2_clk_line),
    .ps2_data_i   (ps2_data_line),
    .ps2_clk_oe_o (ps2_clk_oe_o),
    .ps2_data_oe_o(ps2_data_oe_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (err_o) begin
      err_cnt   <= err_cnt + 1;
      err_cyc   <= cyc;
      last_code <= err_code_o;
    end
    if (valid_i && ready_o && reset_ni) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] b);
    @(negedge clk);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Measures the inhibit phase and returns at the request-to-send cycle.
  task automatic wait_rts(output int inh_len, output int inh_data,
                          output logic rts_data, output int rts_c);
    int g;
    inh_len = 0; inh_data = 0;
    g = 0;
    while (!ps2_clk_oe_o && g < 20) begin @(negedge clk); g++; end
    if (!ps2_clk_oe_o) chk("inhibit_start_timeout", 0, 1);
    g = 0;
    while (ps2_clk_oe_o && g < 10000) begin
      inh_len++;
      if (ps2_data_oe_o) inh_data++;
      @(negedge clk);
      g++;
    end
    if (ps2_clk_oe_o) chk("inhibit_end_timeout", 0, 1);
    rts_data = ps2_data_oe_o;
    rts_c    = cyc;
  endtask

  // Device model: 10 clocks with data sampled on rising edges, then the
  // acknowledge clock with data pulled low when do_ack is set.
  task automatic bfm_frame(input int half, input bit do_ack, input int glitch_after,
                           output logic [9:0] bits, output int inh_len,
                           output int inh_data, output logic rts_data);
    int rts_c;
    bits = '0;
    wait_rts(inh_len, inh_data, rts_data, rts_c);
    repeat (half) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bfm_clk = 1'b0;
      repeat (half) @(negedge clk);
      bfm_clk = 1'b1;
      bits[i] = ps2_data_line;
      if (glitch_after == i + 1) begin
        repeat (half / 2) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (half - half / 2 - 3) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
    end
    bfm_data_low = do_ack;
    repeat (4) @(negedge clk);
    bfm_clk = 1'b0;
    repeat (half) @(negedge clk);
    bfm_clk = 1'b1;
    repeat (2) @(negedge clk);
    bfm_data_low = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_result(input int d0, input int e0);
    int g;
    g = 0;
    while (done_cnt == d0 && err_cnt == e0 && g < 5000) begin @(negedge clk); g++; end
    if (done_cnt == d0 && err_cnt == e0) chk("result_timeout", 0, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    int il, id, rc, d0, e0, a0;
    logic rd;

    // Reset state
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_code", err_code_o, 0);
    chk("rst_clk_oe", ps2_clk_oe_o, 0);
    chk("rst_data_oe", ps2_data_oe_o, 0);

    // 0xED at 12.5 kHz, acknowledged
    d0 = done_cnt; e0 = err_cnt;
    start(8'hED);
    chk("ed_accept_clk_low", ps2_clk_oe_o, 1);
    chk("ed_busy", busy_o, 1);
    bfm_frame(1000, 1'b1, 0, bits, il, id, rd);
    wait_result(d0, e0);
    @(negedge clk);
    chk("ed_inhibit_len", il, INH_CYC);
    chk("ed_inhibit_data_cycles", id, 1);
    chk("ed_rts_data_low", rd, 1);
    chk("ed_bits", bits[7:0], 8'hED);
    chk("ed_parity", bits[8], 1);
    chk("ed_stop", bits[9], 1);
    chk("ed_done_count", done_cnt - d0, 1);
    chk("ed_err_count", err_cnt - e0, 0);
    chk("ed_ready_after", ready_o, 1);

    // 0x00, device does not acknowledge
    d0 = done_cnt; e0 = err_cnt;
    start(8'h00);
    bfm_frame(50, 1'b0, 0, bits, il, id, rd);
    wait_result(d0, e0);
    @(negedge clk);
    chk("nak_bits", bits[7:0], 8'h00);
    chk("nak_parity", bits[8], 1);
    chk("nak_err_count", err_cnt - e0, 1);
    chk("nak_done_count", done_cnt - d0, 0);
    chk("nak_code", last_code, 2'b10);
    chk("nak_ready", ready_o, 1);

    // 0xFF, device never clocks
    d0 = done_cnt; e0 = err_cnt;
    start(8'hFF);
    wait_rts(il, id, rd, rc);
    wait_result(d0, e0);
    @(negedge clk);
    chk("to_latency", err_cyc - rc, TO_CYC);
    chk("to_code", last_code, 2'b01);
    chk("to_done_count", done_cnt - d0, 0);
    chk("to_clk_oe", ps2_clk_oe_o, 0);
    chk("to_data_oe", ps2_data_oe_o, 0);
    chk("to_ready", ready_o, 1);
    chk("to_err_low", err_o, 0);
    chk("to_code_held", err_code_o, 2'b01);

    // valid_i held high: 0xAA then 0x55
    a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    data_i  = 8'hAA;
    valid_i = 1'b1;
    @(negedge clk);
    data_i  = 8'h55;
    bfm_frame(50, 1'b1, 0, bits, il, id, rd);
    wait_result(d0, e0);
    repeat (3) @(negedge clk);
    valid_i = 1'b0;
    chk("b2b_accept_count", acc_cnt - a0, 2);
    chk("b2b_accept_gap", acc_cyc - done_cyc, 1);
    chk("b2b_first_bits", bits[7:0], 8'hAA);
    d0 = done_cnt; e0 = err_cnt;
    bfm_frame(50, 1'b1, 0, bits, il, id, rd);
    wait_result(d0, e0);
    @(negedge clk);
    chk("b2b_second_bits", bits[7:0], 8'h55);
    chk("b2b_second_done", done_cnt - d0, 1);

    // Reset asserted at bit 4 of 0xF0
    start(8'hF0);
    wait_rts(il, id, rd, rc);
    repeat (50) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bfm_clk = 1'b0;
      repeat (50) @(negedge clk);
      bfm_clk = 1'b1;
      repeat (50) @(negedge clk);
    end
    chk("rst4_data_oe_before", ps2_data_oe_o, 1);
    reset_ni = 1'b0;
    #1;
    chk("rst4_clk_oe_async", ps2_clk_oe_o, 0);
    chk("rst4_data_oe_async", ps2_data_oe_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    chk("rst4_ready", ready_o, 1);
    chk("rst4_busy", busy_o, 0);

    // 3-cycle clock glitch after the third rising edge
    d0 = done_cnt; e0 = err_cnt;
    start(8'hED);
    bfm_frame(100, 1'b1, 3, bits, il, id, rd);
    wait_result(d0, e0);
    @(negedge clk);
`ifdef PS2_TX_CLK_FILTER_EN
    chk("glitch_bits", bits[7:0], 8'hED);
    chk("glitch_done_count", done_cnt - d0, 1);
    chk("glitch_err_count", err_cnt - e0, 0);
`else
    chk("glitch_bits", bits[7:0], 8'hF5);
    chk("glitch_err_count", err_cnt - e0, 1);
    chk("glitch_code", last_code, 2'b10);
    chk("glitch_done_count", done_cnt - d0, 0);
`endif
    repeat (5) @(negedge clk);
    chk("final_ready", ready_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter. It sends one command byte at a time to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), over the same open-drain clock and data lines that the `ps2kbd` receiver monitors. It performs the full host request sequence: clock inhibit, request-to-send, 8 data bits, odd parity, stop bit, then checks the device acknowledge. The byte the device returns (0xFA) is received by `ps2kbd`; the top level ignores `ps2kbd` strobes while `busy_o` is high.

## Interface
- `FREQ_HZ`, 25000000: `clk` frequency in Hz.
- `INHIBIT_US`, 100: clock-inhibit duration in µs. Cycle count `INH_CYC` = FREQ_HZ/1000000*INHIBIT_US.
- `TIMEOUT_US`, 15000: maximum allowed gap between consecutive device clock events. Cycle count `TO_CYC` is derived the same way.

Ports:
- `clk`  in  1  system clock.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `data_i`  in  8  command byte to send.
- `valid_i`  in  1  request to send `data_i`.
- `ready_o`  out  1  high only in IDLE; a byte is accepted when `valid_i && ready_o`.
- `busy_o`  out  1  high from acceptance until `done_o` or `err_o`.
- `done_o`  out  1  one-cycle pulse: frame sent and acknowledged.
- `err_o`  out  1  one-cycle pulse: frame failed.
- `err_code_o`  out  2  valid with `err_o`: 01 = timeout, 10 = no acknowledge. Holds its value until the next error.
- `ps2_clk_i`  in  1  raw PS/2 clock line (asynchronous).
- `ps2_data_i`  in  1  raw PS/2 data line (asynchronous).
- `ps2_clk_oe_o`  out  1  1 = drive the clock line low; 0 = release it.
- `ps2_data_oe_o`  out  1  1 = drive the data line low; 0 = release it.

## Operation
- Both PS/2 inputs pass through a 2-flop synchronizer. `fall` is a one-cycle pulse on each high-to-low transition of the synchronized (optionally filtered) clock.
- The latched byte is `sh`. Odd parity `par` = ~^sh. The bit index `n` is a 4-bit counter.
- State IDLE:
  - `ready_o`=1, both OEs 0.
  - On accept: latch `sh`, `n`=0, go to INHIBIT.
- State INHIBIT:
  - `ps2_clk_oe_o`=1 for exactly INH_CYC cycles.
  - On the last of those cycles, also set `ps2_data_oe_o`=1. This is the start bit; go to RTS.
- State RTS:
  - One cycle: `ps2_clk_oe_o`=0, `ps2_data_oe_o` stays 1. Go to BITS.
- State BITS: on each `fall`, increment `n` and drive:
  - `n`=1..8: `ps2_data_oe_o` = ~sh[n-1] (LSB first).
  - `n`=9: `ps2_data_oe_o` = ~`par`.
  - `n`=10: `ps2_data_oe_o`=0 (stop bit, line released). Go to ACK.
- State ACK:
  - On the next `fall`, sample synchronized data.
  - 0: go to WAIT_IDLE.
  - 1: `err_o` with code 10, go to IDLE.
- State WAIT_IDLE:
  - When synchronized clock = 1 and data = 1: `done_o` pulse, go to IDLE.
- Timeout:
  - A cycle counter runs in BITS, ACK and WAIT_IDLE. It clears on entry to BITS and on each `fall`.
  - Reaching TO_CYC: `err_o` with code 01, both OEs 0, go to IDLE.
- Simultaneous `fall` and timeout in the same cycle: `fall` wins.
- `valid_i` outside IDLE is ignored; there is no queueing.

## Timing
- Reset values: state IDLE, `ready_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0, `err_code_o`=00, both OEs 0.
- Asserting `reset_ni` releases both lines immediately, including mid-frame.
- Accept-to-clock-low latency: 1 cycle (OE registered).
- Data low is asserted on the last inhibit cycle; the clock is released 1 cycle later.
- Input latency: the data OE update follows the raw clock falling edge by 3 cycles (sync + edge detect + register), or 3+FILT cycles with the filter enabled. At 10–16.7 kHz PS/2 clocking this is well within the clock-low half period.
- `done_o`/`err_o` to `ready_o`=1: same cycle as the pulse is deasserted, i.e. IDLE on the following cycle. Back-to-back accepts are 1 cycle apart at minimum.

## Configuration
- `PS2_TX_CLK_FILTER_EN` defined:
  - The synchronized clock passes through a majority-free stability filter of FILT=8 cycles.
  - The filtered clock changes only after 8 consecutive equal samples.
  - Glitches shorter than 8 cycles produce no `fall`.
- Undefined: `fall` is derived directly from the 2-flop synchronized clock, with no filter latency.

## Test plan
- Send 0xED with a device BFM clocking at 12.5 kHz and acking:
  - Clock held low for 2500 cycles; data low, then clock released 1 cycle later.
  - Bits sampled on rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done_o` pulses once, `err_o` stays 0.
- Send 0x00 with the BFM leaving data high on the ack clock:
  - Parity bit 1.
  - `err_o` pulse with `err_code_o`=10, then IDLE.
- Send 0xFF with the BFM never clocking:
  - `err_o` with code 01 exactly TO_CYC cycles after RTS.
  - Both OEs 0 afterwards.
- Hold `valid_i` high with 0xAA then 0x55 throughout a frame:
  - Only one accept while busy.
  - Second accept occurs the cycle after `ready_o` returns.
- Assert `reset_ni` low at bit 4:
  - Both OEs 0 asynchronously, before the next `clk` edge.
  - After release the block is in IDLE with `ready_o`=1.
- Inject a 3-cycle low glitch on `ps2_clk_i` mid-bit:
  - With `PS2_TX_CLK_FILTER_EN`: no bit advance, frame completes normally.
  - Without it: the bit index advances and the BFM reports a parity/ack failure.
